// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types for the I2C transfer sequencer
// S_HOLD exists only when I2C_SEQ_RSTART_EN is defined.
package i2c_pkg;

  localparam int ADDR_W = 7;

  typedef enum logic [2:0] {
    CMD_START     = 3'd0,
    CMD_WRITE     = 3'd1,
    CMD_READ_ACK  = 3'd2,
    CMD_READ_NACK = 3'd3,
    CMD_STOP      = 3'd4
  } eng_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_ADDR    = 3'd2,
    S_TX_DATA = 3'd3,
    S_RX_DATA = 3'd4,
`ifdef I2C_SEQ_RSTART_EN
    S_STOP    = 3'd5,
    S_HOLD    = 3'd6
`else
    S_STOP    = 3'd5
`endif
  } seq_state_t;

endpackage

// File: rtl/i2c_xfer_sequencer.sv
// rtl/i2c_xfer_sequencer.sv - sequences START, address, N data bytes and STOP through the byte engine
// Repeated start (HOLD state, no_stop) is compiled in with I2C_SEQ_RSTART_EN.
module i2c_xfer_sequencer
  import i2c_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               go,
  input  logic [ADDR_W-1:0]  address,
  input  logic               read,
  input  logic [COUNT_W-1:0] byte_count,
  input  logic               no_stop,
  input  logic               abort,
  input  logic               clear_error,
  output logic               busy,
  output logic               done,
  output logic               nack_err,
  output logic [COUNT_W-1:0] bytes_left,
  input  logic               tx_empty,
  input  logic [7:0]         tx_rd_data,
  output logic               tx_rd_request,
  input  logic               rx_full,
  output logic [7:0]         rx_wr_data,
  output logic               rx_wr_request,
  output logic [2:0]         eng_cmd,
  output logic [7:0]         eng_data,
  output logic               eng_valid,
  input  logic               eng_ready,
  input  logic               eng_done,
  input  logic               eng_ack,
  input  logic [7:0]         eng_rd_data
);

  seq_state_t         state_q, state_d, fin_state;
  eng_cmd_t           cmd_w;
  logic               issued_q, issued_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               read_q, read_d;
  logic               silent_q, silent_d;
  logic [COUNT_W-1:0] bytes_left_q, bytes_left_d, left_dec;
  logic               nack_err_q, nack_err_d;
  logic               done_q, done_d;
  logic               tx_pop_q, tx_pop_d;
  logic               rx_push_q, rx_push_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               accept, last_byte, load;

`ifdef I2C_SEQ_RSTART_EN
  logic no_stop_q, no_stop_d;
  assign fin_state = no_stop_q ? S_HOLD : S_STOP;
  assign load      = go && (state_q == S_IDLE || state_q == S_HOLD);
`else
  logic unused_no_stop;
  assign unused_no_stop = no_stop;
  assign fin_state      = S_STOP;
  assign load           = go && (state_q == S_IDLE);
`endif

  assign accept    = eng_valid && eng_ready;
  assign last_byte = (bytes_left_q <= COUNT_W'(1));
  assign left_dec  = (bytes_left_q == '0) ? '0 : bytes_left_q - COUNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      issued_q     <= 1'b0;
      addr_q       <= '0;
      read_q       <= 1'b0;
      silent_q     <= 1'b0;
      bytes_left_q <= '0;
      nack_err_q   <= 1'b0;
      done_q       <= 1'b0;
      tx_pop_q     <= 1'b0;
      rx_push_q    <= 1'b0;
      rx_data_q    <= '0;
`ifdef I2C_SEQ_RSTART_EN
      no_stop_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      addr_q       <= addr_d;
      read_q       <= read_d;
      silent_q     <= silent_d;
      bytes_left_q <= bytes_left_d;
      nack_err_q   <= nack_err_d;
      done_q       <= done_d;
      tx_pop_q     <= tx_pop_d;
      rx_push_q    <= rx_push_d;
      rx_data_q    <= rx_data_d;
`ifdef I2C_SEQ_RSTART_EN
      no_stop_q    <= no_stop_d;
`endif
    end
  end

  // issued_q marks the command as accepted and awaiting eng_done
  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    addr_d       = addr_q;
    read_d       = read_q;
    silent_d     = silent_q;
    bytes_left_d = bytes_left_q;
    nack_err_d   = nack_err_q;
    done_d       = 1'b0;
    tx_pop_d     = 1'b0;
    rx_push_d    = 1'b0;
    rx_data_d    = rx_data_q;
`ifdef I2C_SEQ_RSTART_EN
    no_stop_d    = no_stop_q;
`endif
    if (clear_error) nack_err_d = 1'b0;
    if (accept)      issued_d   = 1'b1;
    if (eng_done)    issued_d   = 1'b0;
    case (state_q)
      S_IDLE:  if (go) state_d = S_START;
      S_START: if (eng_done) state_d = abort ? S_STOP : S_ADDR;
      S_ADDR: begin
        if (eng_done) begin
          if (!eng_ack) begin
            nack_err_d = 1'b1;
            state_d    = S_STOP;
          end else if (abort)              state_d = S_STOP;
          else if (bytes_left_q == '0)     state_d = fin_state;
          else if (read_q)                 state_d = S_RX_DATA;
          else                             state_d = S_TX_DATA;
        end
      end
      S_TX_DATA: begin
        tx_pop_d = accept;
        if (eng_done) begin
          bytes_left_d = left_dec;
          if (!eng_ack) begin
            nack_err_d = 1'b1;
            state_d    = S_STOP;
          end else if (abort)  state_d = S_STOP;
          else if (last_byte)  state_d = fin_state;
        end else if (!issued_q && tx_empty && abort) begin
          state_d = S_STOP;
        end
      end
      S_RX_DATA: begin
        if (eng_done) begin
          rx_push_d    = 1'b1;
          rx_data_d    = eng_rd_data;
          bytes_left_d = left_dec;
          if (abort)          state_d = S_STOP;
          else if (last_byte) state_d = fin_state;
        end else if (!issued_q && rx_full && abort) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (eng_done) begin
          done_d   = !silent_q;
          silent_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
`ifdef I2C_SEQ_RSTART_EN
      // bus is still owned here; abort releases it without a second done
      S_HOLD: begin
        if (abort) begin
          silent_d = 1'b1;
          state_d  = S_STOP;
        end else if (go) begin
          state_d  = S_START;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef I2C_SEQ_RSTART_EN
    if (state_d == S_HOLD && state_q != S_HOLD) done_d = 1'b1;
    if (load && !abort) no_stop_d = no_stop;
`endif
    if (load && state_d == S_START) begin
      addr_d       = address;
      read_d       = read;
      bytes_left_d = byte_count;
    end
  end

  always_comb begin
    eng_valid = 1'b0;
    cmd_w     = CMD_START;
    eng_data  = '0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE:  busy = 1'b0;
      S_START: eng_valid = !issued_q;
      S_ADDR: begin
        eng_valid = !issued_q;
        cmd_w     = CMD_WRITE;
        eng_data  = {addr_q, read_q};
      end
      S_TX_DATA: begin
        eng_valid = !issued_q && !tx_empty;
        cmd_w     = CMD_WRITE;
        eng_data  = tx_rd_data;
      end
      S_RX_DATA: begin
        eng_valid = !issued_q && !rx_full;
        cmd_w     = last_byte ? CMD_READ_NACK : CMD_READ_ACK;
      end
      S_STOP: begin
        eng_valid = !issued_q;
        cmd_w     = CMD_STOP;
      end
      default: busy = 1'b0;
    endcase
  end

  assign eng_cmd       = cmd_w;
  assign done          = done_q;
  assign nack_err      = nack_err_q;
  assign bytes_left    = bytes_left_q;
  assign tx_rd_request = tx_pop_q;
  assign rx_wr_request = rx_push_q;
  assign rx_wr_data    = rx_data_q;

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// tb/tb_i2c_xfer_sequencer.sv - self-checking bench for i2c_xfer_sequencer with engine and FIFO models
// Repeated-start steps are compiled in with I2C_SEQ_RSTART_EN.
module tb_i2c_xfer_sequencer;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n, go, read, no_stop, abort, clear_error;
  logic [6:0] address;
  logic [7:0] byte_count, bytes_left, tx_rd_data, rx_wr_data, eng_data, eng_rd_data;
  logic       busy, done, nack_err, tx_empty, tx_rd_request, rx_full, rx_wr_request;
  logic [2:0] eng_cmd;
  logic       eng_valid, eng_ready, eng_done, eng_ack;

  i2c_xfer_sequencer #(.COUNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .address(address), .read(read),
    .byte_count(byte_count), .no_stop(no_stop), .abort(abort), .clear_error(clear_error),
    .busy(busy), .done(done), .nack_err(nack_err), .bytes_left(bytes_left),
    .tx_empty(tx_empty), .tx_rd_data(tx_rd_data), .tx_rd_request(tx_rd_request),
    .rx_full(rx_full), .rx_wr_data(rx_wr_data), .rx_wr_request(rx_wr_request),
    .eng_cmd(eng_cmd), .eng_data(eng_data), .eng_valid(eng_valid), .eng_ready(eng_ready),
    .eng_done(eng_done), .eng_ack(eng_ack), .eng_rd_data(eng_rd_data)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [7:0]  tx_q[$], rd_feed[$], rx_got[$], tx_src[$], rd_src[$], exp_rx[$];
  logic [10:0] cmd_log[$], exp_cmds[$];
  int pops = 0, done_cnt = 0, busy_at_done = 0, nack_at = -1;
  int exp_pops, exp_left, done_base;
  logic exp_nack;

  // engine + FIFO environment: everything is driven at the falling edge
  bit         eng_busy = 1'b0;
  int         lat = 0, wr_idx = 0;
  logic [2:0] cur_cmd = 3'd0;
  initial begin
    eng_ready = 1'b0; eng_done = 1'b0; eng_ack = 1'b0; eng_rd_data = 8'h00;
    tx_empty = 1'b1; tx_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (!reset_n) begin
        eng_busy = 1'b0; lat = 0; eng_ready = 1'b0;
      end else begin
        if (tx_rd_request) begin
          if (tx_q.size() > 0) void'(tx_q.pop_front());
          pops++;
        end
        if (rx_wr_request) rx_got.push_back(rx_wr_data);
        if (done) begin
          done_cnt++;
          if (busy) busy_at_done++;
        end
        if (eng_busy) begin
          lat--;
          if (lat == 0) begin
            eng_busy = 1'b0;
            eng_done = 1'b1;
            if (cur_cmd == CMD_WRITE) begin
              eng_ack = (wr_idx != nack_at);
              wr_idx++;
            end else if (cur_cmd == CMD_READ_ACK || cur_cmd == CMD_READ_NACK) begin
              eng_rd_data = (rd_feed.size() > 0) ? rd_feed.pop_front() : 8'hEE;
            end
          end
        end
        eng_ready = !eng_busy && ($urandom_range(0, 3) != 0);
      end
      tx_empty   = (tx_q.size() == 0);
      tx_rd_data = tx_empty ? 8'h00 : tx_q[0];
      #1;
      if (reset_n && eng_valid && eng_ready) begin
        cmd_log.push_back({eng_cmd, eng_data});
        cur_cmd  = eng_cmd;
        eng_busy = 1'b1;
        lat      = $urandom_range(1, 3);
        if (eng_cmd == CMD_START) wr_idx = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // transfer-level reference: the command list the bus must see, built from the transfer rules
  task automatic build_model(input bit rd, input logic [6:0] a, input int cnt,
                             input int nk, input int abort_after, input bit hold);
    exp_cmds.delete(); exp_rx.delete();
    exp_pops = 0; exp_nack = 1'b0; exp_left = cnt;
    exp_cmds.push_back({CMD_START, 8'h00});
    exp_cmds.push_back({CMD_WRITE, a, rd});
    if (nk == 0) exp_nack = 1'b1;
    else begin
      for (int i = 1; i <= cnt; i++) begin
        if (rd) begin
          exp_cmds.push_back({(i == cnt) ? CMD_READ_NACK : CMD_READ_ACK, 8'h00});
          exp_rx.push_back(rd_src[i-1]);
        end else begin
          exp_cmds.push_back({CMD_WRITE, tx_src[i-1]});
          exp_pops++;
        end
        exp_left = cnt - i;
        if (!rd && nk == i) begin exp_nack = 1'b1; break; end
        if (abort_after == i) break;
      end
    end
    if (!hold) exp_cmds.push_back({CMD_STOP, 8'h00});
  endtask

  task automatic start_xfer(input bit rd, input logic [6:0] a, input int cnt, input int nk,
                            input int abort_after, input bit hold, input bit ns, input bit preload);
    nack_at = nk;
    cmd_log.delete(); rx_got.delete(); pops = 0;
    if (preload && !rd) foreach (tx_src[i]) tx_q.push_back(tx_src[i]);
    rd_feed.delete();
    foreach (rd_src[i]) rd_feed.push_back(rd_src[i]);
    build_model(rd, a, cnt, nk, abort_after, hold);
    done_base = done_cnt;
    @(negedge clk);
    address = a; read = rd; byte_count = 8'(cnt); no_stop = ns; go = 1'b1;
    @(negedge clk);
    go = 1'b0; address = 7'($urandom); read = 1'($urandom); byte_count = 8'($urandom); no_stop = 1'b0;
    #2;
    chk("go_busy", busy, 1);
    chk("go_valid", eng_valid, 1);
    chk("go_cmd", eng_cmd, CMD_START);
  endtask

  task automatic finish_xfer(input string tag);
    int k = 0;
    while (done_cnt == done_base && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    #2;
    chk({tag, "_done_once"}, done_cnt - done_base, 1);
    chk({tag, "_ncmd"}, cmd_log.size(), exp_cmds.size());
    for (int i = 0; i < exp_cmds.size() && i < cmd_log.size(); i++) begin
      chk({tag, "_cmd"}, cmd_log[i][10:8], exp_cmds[i][10:8]);
      if (exp_cmds[i][10:8] == CMD_WRITE) chk({tag, "_wdata"}, cmd_log[i][7:0], exp_cmds[i][7:0]);
    end
    chk({tag, "_pops"}, pops, exp_pops);
    chk({tag, "_nrx"}, rx_got.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < rx_got.size(); i++)
      chk({tag, "_rxdata"}, rx_got[i], exp_rx[i]);
    chk({tag, "_nack"}, nack_err, exp_nack);
    chk({tag, "_left"}, bytes_left, exp_left);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
  endtask

  task automatic wait_log(input int n);
    int k = 0;
    while (cmd_log.size() < n && k < 500) begin
      @(negedge clk);
      #2;
      k++;
    end
  endtask

  initial begin
    bit rd_r;
    int cnt_r, nk_r;
    reset_n = 1'b0; go = 1'b0; address = '0; read = 1'b0; byte_count = '0;
    no_stop = 1'b0; abort = 1'b0; clear_error = 1'b0; rx_full = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", eng_valid, 0);
    chk("rst_nack", nack_err, 0);
    chk("rst_left", bytes_left, 0);
    chk("rst_pop", tx_rd_request, 0);
    chk("rst_push", rx_wr_request, 0);
    reset_n = 1'b1;

    // write 0x50, A1 B2 C3; a go while busy must be ignored
    tx_src = {8'hA1, 8'hB2, 8'hC3}; rd_src.delete();
    start_xfer(0, 7'h50, 3, -1, -1, 0, 0, 1);
    @(negedge clk); go = 1'b1; address = 7'h7F; byte_count = 8'd9;
    @(negedge clk); go = 1'b0;
    finish_xfer("wr");

    // read 0x50, 5A 6B
    tx_src.delete(); rd_src = {8'h5A, 8'h6B};
    start_xfer(1, 7'h50, 2, -1, -1, 0, 0, 1);
    finish_xfer("rd");

    // address NACK leaves TX data untouched; clear_error then clears the flag
    tx_src = {8'h01, 8'h02}; rd_src.delete();
    start_xfer(0, 7'h50, 2, 0, -1, 0, 0, 1);
    finish_xfer("anack");
    chk("anack_txleft", tx_q.size(), 2);
    tx_q.delete();
    @(negedge clk); clear_error = 1'b1;
    @(negedge clk); clear_error = 1'b0; #2;
    chk("clr_nack", nack_err, 0);

    // TX underflow stall after the address, filled later
    tx_src = {8'h3C, 8'hC3}; rd_src.delete();
    start_xfer(0, 7'h21, 2, -1, -1, 0, 0, 0);
    wait_log(2);
    repeat (8) @(negedge clk);
    #2;
    chk("txstall_valid", eng_valid, 0);
    chk("txstall_busy", busy, 1);
    chk("txstall_ncmd", cmd_log.size(), 2);
    repeat (2) @(negedge clk);
    foreach (tx_src[i]) tx_q.push_back(tx_src[i]);
    finish_xfer("txstall");

    // RX full holds off reads
    rx_full = 1'b1;
    tx_src.delete(); rd_src = {8'h91, 8'h92};
    start_xfer(1, 7'h33, 2, -1, -1, 0, 0, 1);
    wait_log(2);
    repeat (8) @(negedge clk);
    #2;
    chk("rxstall_valid", eng_valid, 0);
    chk("rxstall_ncmd", cmd_log.size(), 2);
    rx_full = 1'b0;
    finish_xfer("rxstall");

    // abort while the 2nd of 4 write bytes is in flight
    tx_src = {8'h10, 8'h20, 8'h30, 8'h40}; rd_src.delete();
    start_xfer(0, 7'h44, 4, -1, 2, 0, 0, 1);
    wait_log(4);
    abort = 1'b1;
    finish_xfer("abort");
    abort = 1'b0;
    chk("abort_txleft", tx_q.size(), 2);
    tx_q.delete();

    // asynchronous reset in the middle of a read
    tx_src.delete(); rd_src = {8'h01, 8'h02, 8'h03, 8'h04};
    start_xfer(1, 7'h55, 4, -1, -1, 0, 0, 1);
    wait_log(3);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", eng_valid, 0);
    chk("mrst_cmd", eng_cmd, 0);
    chk("mrst_data", eng_data, 0);
    chk("mrst_done", done, 0);
    chk("mrst_left", bytes_left, 0);
    chk("mrst_push", rx_wr_request, 0);
    chk("mrst_rxdata", rx_wr_data, 0);
    chk("mrst_pop", tx_rd_request, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd_feed.delete(); tx_q.delete();
    repeat (2) @(negedge clk);

    // randomized transfers
    for (int it = 0; it < 8; it++) begin
      rd_r  = 1'($urandom_range(0, 1));
      cnt_r = $urandom_range(0, 5);
      nk_r  = -1;
      tx_src.delete(); rd_src.delete();
      for (int i = 0; i < cnt_r; i++) begin
        tx_src.push_back(8'($urandom));
        rd_src.push_back(8'($urandom));
      end
      if ($urandom_range(0, 3) == 0) nk_r = rd_r ? 0 : $urandom_range(0, cnt_r);
      start_xfer(rd_r, 7'($urandom), cnt_r, nk_r, -1, 0, 0, 1);
      finish_xfer("rand");
      tx_q.delete();
      if (exp_nack) begin
        @(negedge clk); clear_error = 1'b1;
        @(negedge clk); clear_error = 1'b0; #2;
        chk("rand_clr", nack_err, 0);
      end
    end

`ifdef I2C_SEQ_RSTART_EN
    // write with no_stop parks in HOLD, then a read follows with a repeated START
    tx_src = {8'h11}; rd_src.delete();
    start_xfer(0, 7'h2C, 1, -1, -1, 1, 1, 1);
    finish_xfer("hold_wr");
    chk("hold_valid", eng_valid, 0);
    tx_src.delete(); rd_src = {8'h77};
    start_xfer(1, 7'h2C, 1, -1, -1, 0, 0, 1);
    finish_xfer("rs_rd");
`else
    // no_stop has no effect without repeated-start support
    tx_src = {8'h11}; rd_src.delete();
    start_xfer(0, 7'h2C, 1, -1, -1, 0, 1, 1);
    finish_xfer("nostop_ign");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
